usb_rx_data_buffer: RTL
=======================

Name: usb_rx_data_buffer

Overview:
Receive-side packet data buffer. It sits directly downstream of usb_rx and captures each byte usb_rx presents on rx_packet_data when usb_rx pulses store_rx_packet. It holds up to 64 bytes, which the host-side interface drains in order. It reports occupancy so the protocol controller can judge packet length and buffer status.

Parameters:
DEPTH, 64, number of byte entries; must be a power of two (pointer width = log2(DEPTH)).
OCC_W, 7, width of buffer_occupancy; must hold 0..DEPTH inclusive.

Ports:
clk  input  1  system clock; all state updates on rising edge
n_rst  input  1  asynchronous active-low reset
store_rx_packet_data  input  1  write strobe; connected to usb_rx store_rx_packet; one byte per high cycle
rx_packet_data  input  8  write byte from usb_rx, sampled when store_rx_packet_data=1
get_rx_data  input  1  read strobe from host side; pops the head byte when high and not empty
flush  input  1  synchronous clear of all contents
rx_data  output  8  head byte (first-word fall-through); 8'h00 when empty
buffer_occupancy  output  OCC_W  bytes currently stored, 0..DEPTH
empty  output  1  buffer_occupancy==0
full  output  1  buffer_occupancy==DEPTH
overflow  output  1  sticky: a write was attempted while full (see Optional Feature)

Behaviour:
- Reset (n_rst=0, async): write pointer=0, read pointer=0, occupancy=0, overflow=0. Hence rx_data=8'h00, empty=1, full=0. Storage array is not reset.
- Write: store_rx_packet_data=1 and not full -> mem[wptr]<=rx_packet_data; wptr+1 (wraps DEPTH-1 -> 0); occupancy+1. The byte is visible on rx_data the cycle after the edge if the buffer was empty.
- Read: get_rx_data=1 and not empty -> rptr+1 (wraps); occupancy-1. rx_data is combinational mem[rptr], so the next byte appears immediately after the edge.
- Read while empty: ignored; no pointer or occupancy change.
- Write while full: byte dropped; pointers and occupancy unchanged; overflow handling per Optional Feature.
- Simultaneous read and write, 0<occ<DEPTH: both happen; occupancy unchanged.
- Simultaneous read and write while empty: write accepted, read ignored; occ -> 1.
- Simultaneous read and write while full: both happen (the slot freed by the read is usable); occupancy stays DEPTH; no overflow.
- flush=1: highest priority. On the next edge, pointers=0, occupancy=0, overflow=0. Any write or read in the same cycle is discarded.
- Latency: write-to-visible is 1 cycle; read-to-next-data is 1 cycle.
- empty, full and buffer_occupancy are decoded from the occupancy register. They have no combinational path from the strobes.
- Occupancy is kept as an explicit counter, not derived from pointer difference, so that 0 and DEPTH are distinguishable.

Optional Feature:
Macro USB_RX_BUF_OVF_EN.
- Defined: overflow is set on the edge where store_rx_packet_data=1, full=1 and get_rx_data=0. It holds at 1 until flush or reset.
- Not defined: overflow is tied to 1'b0, with no flop. Writes while full are still silently dropped.

Test Plan:
- Reset mid-fill: write 5 bytes, then assert n_rst low asynchronously between edges. Outputs go to occ=0, empty=1, rx_data=8'h00 immediately.
- In-order capture: 4 writes of 8'hA5,8'h3C,8'hFF,8'h01, then occ=4 and rx_data=8'hA5. Four get_rx_data pulses return 3C, FF, 01, then empty=1, rx_data=00.
- Fill and wrap: 64 writes of 8'h00..8'h3F give full=1, occ=64. Then 10 reads, then 10 writes of 8'h40..8'h49, give occ=64. Draining all 64 returns 8'h0A..8'h49 in order.
- Overflow: when full, write 8'hEE with no read. Occ stays 64 and contents are unchanged. overflow=1 if USB_RX_BUF_OVF_EN, else 0. Then flush gives overflow=0, occ=0.
- Simultaneous strobes: when empty, read+write 8'h77 gives occ=1, rx_data=77. When full, read+write gives occ=64, overflow=0, and the head advances.
- Flush priority: with occ=3, flush+write+read in one cycle gives occ=0, empty=1, and the written byte is not stored.

Source files
------------

// File: rtl/usb_rx_data_buffer.sv
// usb_rx_data_buffer: 64-byte first-word-fall-through receive buffer.
// Ports: clk, n_rst, store/data in, get, flush; rx_data, occupancy, empty/full/overflow (USB_RX_BUF_OVF_EN).
module usb_rx_data_buffer #(
  parameter int DEPTH = 64,
  parameter int OCC_W = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             get_rx_data,
  input  logic             flush,
  output logic [7:0]       rx_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             wr_en, rd_en;

  assign empty            = (occ_q == '0);
  assign full             = (occ_q == OCC_W'(DEPTH));
  assign buffer_occupancy = occ_q;
  assign rx_data          = empty ? 8'h00 : mem_q[rptr_q];

  // A read frees a slot in the same cycle, so a full buffer
  // still accepts a write when it is also being read.
  assign rd_en = get_rx_data & ~empty & ~flush;
  assign wr_en = store_rx_packet_data & (~full | rd_en) & ~flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + PW'(1);
      if (rd_en) rptr_d = rptr_q + PW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= rx_packet_data;
  end

`ifdef USB_RX_BUF_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (flush)
      ovf_d = 1'b0;
    else if (store_rx_packet_data & full & ~get_rx_data)
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule
